// File: rtl/idu_pipe.sv
// idu_pipe: RV32I decode stage feeding a DEPTH-entry FIFO of decoded bundles.
// Compile-time option: define IDU_M_EXT_EN to decode RV32M (funct7=0x01 on OP).
// Decode is combinational on the IFU side; outputs come only from FIFO storage,
// so there is no combinational path from in_* to out_*.
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [4:0]               out_alu_op,
  output logic                     out_reg_wen,
  output logic                     out_mem_wen,
  output logic                     out_mem_ren,
  output logic                     out_use_imm,
  output logic                     out_branch,
  output logic                     out_jump,
  output logic                     out_is_jalr,
  output logic [2:0]               out_funct3,
  output logic                     out_ebreak,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                         OP_REG = 7'b0110011, OP_SYS   = 7'b1110011;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR   = 5'd3,
                         ALU_XOR = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA  = 5'd7,
                         ALU_SLT = 5'd8, ALU_SLTU = 5'd9;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic            reg_wen, mem_wen, mem_ren, use_imm, branch, jump, is_jalr;
    logic [2:0]      funct3;
    logic            ebreak, illegal;
  } bundle_t;

  // Shared funct3 -> ALU mapping for OP and OP-IMM (SUB/SRA patched by caller).
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

  bundle_t            dec;
  logic signed [31:0] imm32;
  logic               ill;
  logic [2:0]         f3;
  logic [6:0]         f7;

  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  // Decode the incoming word; illegal encodings keep their fields but lose all enables.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    ill        = 1'b0;
    dec.pc     = in_pc;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.funct3 = f3;
    dec.alu_op = ALU_ADD;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32 = {in_inst[31:12], 12'b0};
        dec.reg_wen = 1'b1; dec.use_imm = 1'b1;
      end
      OP_JAL: begin
        imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec.reg_wen = 1'b1; dec.jump = 1'b1; dec.use_imm = 1'b1;
      end
      OP_JALR: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.reg_wen = 1'b1; dec.jump = 1'b1; dec.is_jalr = 1'b1; dec.use_imm = 1'b1;
        ill = (f3 != 3'b000);
      end
      OP_BR: begin
        imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        dec.branch = 1'b1;
        case (f3)
          3'b000, 3'b001: dec.alu_op = ALU_SUB;
          3'b100, 3'b101: dec.alu_op = ALU_SLT;
          3'b110, 3'b111: dec.alu_op = ALU_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.reg_wen = 1'b1; dec.mem_ren = 1'b1; dec.use_imm = 1'b1;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_ST: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec.mem_wen = 1'b1; dec.use_imm = 1'b1;
        ill = (f3 > 3'b010);
      end
      OP_IMM: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.reg_wen = 1'b1; dec.use_imm = 1'b1;
        dec.alu_op  = alu_base(f3);
        if (f3 == 3'b001) ill = (f7 != 7'h00);
        if (f3 == 3'b101) begin
          ill = (f7 != 7'h00) && (f7 != 7'h20);
          if (f7 == 7'h20) dec.alu_op = ALU_SRA;
        end
      end
      OP_REG: begin
        dec.reg_wen = 1'b1;
        if (f7 == 7'h01) begin
`ifdef IDU_M_EXT_EN
          dec.alu_op = 5'd10 + {2'b00, f3};
`else
          ill = 1'b1;
`endif
        end else if (f7 == 7'h00) begin
          dec.alu_op = alu_base(f3);
        end else if (f7 == 7'h20) begin
          if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
          else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
          else                   ill = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      OP_SYS: begin
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.use_imm = 1'b1;
        dec.ebreak  = (in_inst == 32'h0010_0073);
        ill = !((in_inst == 32'h0000_0073) || dec.ebreak);
      end
      default: ill = 1'b1;
    endcase
    dec.imm     = XLEN'(imm32);
    dec.illegal = ill;
    if (ill) begin
      dec.reg_wen = 1'b0; dec.mem_wen = 1'b0; dec.mem_ren = 1'b0;
      dec.branch  = 1'b0; dec.jump    = 1'b0; dec.is_jalr = 1'b0;
    end
  end

  bundle_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             push, pop;
  bundle_t          head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = !rst && !flush && (occ_q < CNT_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = occ_q;

  // Next-state for pointers and count; flush empties the FIFO and blocks the enqueue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !push) occ_d = occ_q - 1'b1;
    end
  end

  // Control state; reset dominates flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Bundle storage is data only; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc      = head.pc;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_alu_op  = head.alu_op;
  assign out_reg_wen = head.reg_wen;
  assign out_mem_wen = head.mem_wen;
  assign out_mem_ren = head.mem_ren;
  assign out_use_imm = head.use_imm;
  assign out_branch  = head.branch;
  assign out_jump    = head.jump;
  assign out_is_jalr = head.is_jalr;
  assign out_funct3  = head.funct3;
  assign out_ebreak  = head.ebreak;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: directed instructions with hand-decoded bundles.
module tb_idu_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic        out_reg_wen, out_mem_wen, out_mem_ren, out_use_imm, out_branch, out_jump, out_is_jalr;
  logic [2:0]  out_funct3;
  logic        out_ebreak, out_illegal;
  logic [1:0]  occupancy;

  idu_pipe #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_reg_wen(out_reg_wen),
    .out_mem_wen(out_mem_wen), .out_mem_ren(out_mem_ren), .out_use_imm(out_use_imm),
    .out_branch(out_branch), .out_jump(out_jump), .out_is_jalr(out_is_jalr),
    .out_funct3(out_funct3), .out_ebreak(out_ebreak), .out_illegal(out_illegal),
    .occupancy(occupancy));

  always #5 clk = ~clk;

  // flags order: reg_wen mem_wen mem_ren use_imm branch jump is_jalr
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [6:0]  fl;
    logic [2:0]  f3;
    logic        eb, ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t act_w, mon_e;
  int   checks = 0, failures = 0;

  assign act_w = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
                  out_reg_wen, out_mem_wen, out_mem_ren, out_use_imm, out_branch,
                  out_jump, out_is_jalr, out_funct3, out_ebreak, out_illegal};

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] imm, input logic [4:0] alu,
                              input logic [6:0] fl, input logic [2:0] f3,
                              input logic eb, ill);
    mk = {pc, rs1, rs2, rd, imm, alu, fl, f3, eb, ill};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every dequeue handshake is compared against the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out actual=%0h required=none", act_w);
      end else begin
        mon_e = exp_q.pop_front();
        if (act_w !== mon_e) begin
          failures++;
          $display("FAIL bundle_pc%0h actual=%0h required=%0h", mon_e.pc, act_w, mon_e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] inst, input exp_t e);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = inst; in_pc = e.pc;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) exp_q.push_back(e);
    else chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    chk("drain_left", 128'(exp_q.size()), 0);
  endtask

  exp_t e_addi, e_sub, e_sw;

  initial begin
    e_addi = mk(32'h100, 5'd0, 5'd5, 5'd1, 32'd5, 5'd0, 7'b1001000, 3'd0, 1'b0, 1'b0);
    e_sub  = mk(32'h104, 5'd1, 5'd2, 5'd3, 32'd0, 5'd1, 7'b1000000, 3'd0, 1'b0, 1'b0);
    e_sw   = mk(32'h108, 5'd1, 5'd2, 5'd8, 32'd8, 5'd0, 7'b0101000, 3'd2, 1'b0, 1'b0);

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 0);
    chk("rst_out_valid", 128'(out_valid), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 128'(occupancy), 0);
    chk("rst_in_ready_after", 128'(in_ready), 1);
    chk("empty_fields_zero", 128'(act_w), 0);

    // addi with 1-cycle latency
    out_ready = 1'b1;
    send(32'h0050_0093, e_addi);
    @(negedge clk);
    drain();

    // backpressure: fill, check full and head stability, then release
    out_ready = 1'b0;
    send(32'h4020_81B3, e_sub);
    send(32'h0020_A423, e_sw);
    @(negedge clk);
    chk("full_occupancy", 128'(occupancy), 2);
    chk("full_in_ready", 128'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      chk("head_stable", 128'(act_w), 128'(e_sub));
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    drain();

    // flush with in_valid high while holding two entries
    out_ready = 1'b0;
    send(32'h0050_0093, e_addi);
    send(32'h4020_81B3, e_sub);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h1FC;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 0);
    @(posedge clk);
    exp_q.delete();
    #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occupancy", 128'(occupancy), 0);
    chk("flush_out_valid", 128'(out_valid), 0);
    chk("flush_fields_zero", 128'(act_w), 0);
    repeat (2) @(negedge clk);
    chk("flush_no_accept", 128'(occupancy), 0);

    // decode vectors, streaming with out_ready high
    out_ready = 1'b1;
    send(32'h0010_0073, mk(32'h10C, 5'd0, 5'd1, 5'd0, 32'd1, 5'd0, 7'b0001000, 3'd0, 1'b1, 1'b0));
    send(32'h0000_307F, mk(32'h110, 5'd0, 5'd0, 5'd0, 32'd0, 5'd0, 7'b0000000, 3'd3, 1'b0, 1'b1));
`ifdef IDU_M_EXT_EN
    send(32'h0220_81B3, mk(32'h114, 5'd1, 5'd2, 5'd3, 32'd0, 5'd10, 7'b1000000, 3'd0, 1'b0, 1'b0));
`else
    send(32'h0220_81B3, mk(32'h114, 5'd1, 5'd2, 5'd3, 32'd0, 5'd0, 7'b0000000, 3'd0, 1'b0, 1'b1));
`endif
    send(32'hFE00_0EE3, mk(32'h118, 5'd0, 5'd0, 5'd29, 32'hFFFF_FFFC, 5'd1, 7'b0000100, 3'd0, 1'b0, 1'b0));
    send(32'h1234_50B7, mk(32'h11C, 5'd8, 5'd3, 5'd1, 32'h1234_5000, 5'd0, 7'b1001000, 3'd5, 1'b0, 1'b0));
    send(32'h0080_00EF, mk(32'h120, 5'd0, 5'd8, 5'd1, 32'd8, 5'd0, 7'b1001010, 3'd0, 1'b0, 1'b0));
    send(32'h0000_B083, mk(32'h124, 5'd1, 5'd0, 5'd1, 32'd0, 5'd0, 7'b0001000, 3'd3, 1'b0, 1'b1));
    send(32'h4020_D093, mk(32'h128, 5'd1, 5'd2, 5'd1, 32'h402, 5'd7, 7'b1001000, 3'd5, 1'b0, 1'b0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
Pipelined, parametrised RV32I instruction decode stage. It sits between IFU and EXU. Accepted instructions are decoded combinationally, and the decoded bundles are held in a DEPTH-entry FIFO. The FIFO uses valid/ready handshakes on both sides, supports flush, and detects illegal instructions and ebreak.

Parameters:
XLEN, 32, immediate/datapath width; immediates are sign-extended to XLEN (XLEN >= 32).
PC_W, 32, width of the PC carried alongside each instruction.
DEPTH, 2, decode FIFO entries (power of two, >= 1).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  IFU has an instruction.
in_ready  out  1  stage can accept an instruction.
in_inst  in  32  instruction word.
in_pc  in  PC_W  instruction PC.
flush  in  1  discard all held and incoming instructions.
out_valid  out  1  head bundle valid.
out_ready  in  1  EXU accepts head.
out_pc  out  PC_W  PC of head.
out_rs1/out_rs2/out_rd  out  5 each  register indices (inst[19:15], [24:20], [11:7]).
out_imm  out  XLEN  selected immediate (I/S/B/U/J).
out_alu_op  out  5  ALU operation code.
out_reg_wen, out_mem_wen, out_mem_ren, out_use_imm, out_branch, out_jump, out_is_jalr  out  1 each  control flags.
out_funct3  out  3  raw funct3 (load/store size, branch condition).
out_ebreak  out  1  head is ebreak (0x00100073).
out_illegal  out  1  head is an illegal encoding.
occupancy  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - occupancy=0, read/write pointers=0.
  - out_valid=0. All out_* fields read 0 while empty.
  - in_ready is 0 during the reset cycle.
- Decode:
  - Combinational on in_inst; written into the FIFO on accept (in_valid & in_ready).
- Latency:
  - With the FIFO empty, an instruction accepted at edge N has out_valid=1 in the cycle after edge N (1 cycle).
  - No combinational path from in_* to out_*.
- in_ready:
  - in_ready = !rst & !flush & (occupancy < DEPTH).
  - When full, a same-cycle dequeue does not open in_ready; there is no ready-through path.
- Handshakes:
  - Dequeue on out_valid & out_ready.
  - Simultaneous enqueue and dequeue leave occupancy unchanged.
  - Output fields stay stable while out_valid & !out_ready.
  - Pointers wrap modulo DEPTH.
- Flush (sync):
  - At the edge: occupancy←0, out_valid←0, and the input is not accepted.
  - Flush has priority over enqueue/dequeue. rst has priority over flush.
- ALU codes:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - Loads, stores, jal, jalr, lui and auipc use ADD.
  - Branches: beq/bne→SUB, blt/bge→SLT, bltu/bgeu→SLTU.
- Control flags:
  - reg_wen = R | OP-IMM | load | LUI | AUIPC | JAL | JALR, and forced 0 when illegal.
  - mem_wen = store; mem_ren = load; branch = B-type; jump = JAL | JALR.
  - use_imm = any non-R, non-B type.
- Illegal (sets out_illegal and forces reg_wen/mem_wen/mem_ren/branch/jump to 0):
  - Unknown opcode.
  - R-type funct7 not in {0x00, 0x20}, or 0x20 with funct3 not in {000, 101}.
  - slli with funct7≠0; srli/srai with funct7 not in {0x00, 0x20}.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 > 010.
  - Branch funct3 ∈ {010, 011}.
  - jalr funct3≠0.
  - SYSTEM other than ecall (0x00000073) or ebreak.
- out_ebreak:
  - Set only for exactly 0x00100073, which is legal. It carries no write enables.

Optional Feature:
- Macro IDU_M_EXT_EN.
- Defined: R-type funct7=0x01 decodes RV32M with codes MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17, and reg_wen=1.
- Undefined: funct7=0x01 is illegal.

Test Plan:
- Reset, then in_valid=1, inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, reg_wen=1, use_imm=1.
- Hold out_ready=0, push 0x402081B3 (sub) then 0x0020A423 (sw x2,8(x1)) -> occupancy=2, in_ready=0; head stays sub (alu_op=1) stable; release -> sw with imm=8, mem_wen=1, reg_wen=0.
- FIFO holding 2 entries, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, input not accepted.
- inst=0x00100073 -> out_ebreak=1, illegal=0; inst=0x0000307F -> illegal=1, all enables 0.
- inst=0x022081B3 (mul x3,x1,x2) -> with IDU_M_EXT_EN alu_op=10, reg_wen=1; without it illegal=1, reg_wen=0.
- inst=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, alu_op=1, use_imm=0.
